// File: rtl/ysyx_220066_mem_pkg.sv
// ysyx_220066_mem_pkg
//   Shared definitions for the memory-access stage and any future cache stage
//   that reuses the load aligner:
//     - MemOp encodings (MOP_B .. MOP_WU)
//     - stage state enum
//     - size_of(): access size in bytes from a MemOp
//     - is_unsigned(): zero-extend (1) or sign-extend (0) a load
package ysyx_220066_mem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_D  = 3'b011;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;
    localparam logic [2:0] MOP_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    // Only the low two bits carry the size; bit 2 is signedness.
    function automatic logic [3:0] size_of(input logic [2:0] mem_op);
        return 4'd1 << mem_op[1:0];
    endfunction

    function automatic logic is_unsigned(input logic [2:0] mem_op);
        return mem_op[2];
    endfunction

endpackage

// File: rtl/ysyx_220066_load_align.sv
// ysyx_220066_load_align
//   Combinational load data aligner: selects the addressed bytes out of an
//   aligned read word and sign- or zero-extends them to XLEN.
//   Ports:
//     rsp_data  in  XLEN   aligned read word from memory
//     off       in  OFF_W  byte offset of the access inside the word
//     mem_op    in  3      access size/sign (MemOp encoding)
//     result    out XLEN   extended load value
module ysyx_220066_load_align
    import ysyx_220066_mem_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rsp_data,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       mem_op,
    output logic [XLEN-1:0]  result
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            sign;

    assign shifted = rsp_data >> {off, 3'b000};

    always_comb begin
        keep = '1;
        sign = shifted[XLEN-1];
        case (mem_op[1:0])
            2'b00: begin keep = XLEN'(8'hFF);          sign = shifted[7];  end
            2'b01: begin keep = XLEN'(16'hFFFF);       sign = shifted[15]; end
            2'b10: begin keep = XLEN'(32'hFFFF_FFFF);  sign = shifted[31]; end
            default: ;
        endcase
    end

    // Bits above the access size are filled with the sign bit, or zero for
    // unsigned loads.
    assign result = (shifted & keep) |
                    ((is_unsigned(mem_op) | ~sign) ? '0 : ~keep);

endmodule

// File: rtl/ysyx_220066_mem_stage.sv
// ysyx_220066_mem_stage
//   Memory-access stage between EX and WB. Valid/ready on both pipeline sides,
//   req/rsp data-memory port. Non-memory ops pass through at one per cycle;
//   memory ops hold the stage until the response returns.
//   Optional build macro: YSYX_220066_MISALIGN_CHECK_EN -- when defined, a
//   misaligned access is rejected with out_error and no request is issued.
//   Ports:
//     clk, rst                   clock, async active-high reset
//     in_valid/in_ready          upstream handshake
//     in_RegWr..in_rd            op fields from EX
//     mem_req_*/mem_addr/..      data-memory request (held stable until ready)
//     mem_rsp_*                  data-memory response
//     out_valid/out_ready        downstream handshake
//     out_RegWr..out_nxtpc       op fields to WB
//     ld_pending/ld_rd           in-flight load, for the hazard unit
//
//   state  | meaning
//   IDLE   | stage empty
//   REQ    | memory request presented, waiting for mem_req_ready
//   WAIT   | request accepted, waiting for mem_rsp_valid
//   DONE   | result presented on out_*, waiting for out_ready
module ysyx_220066_mem_stage
    import ysyx_220066_mem_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5,
    parameter int PC_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_RegWr,
    input  logic                in_MemRd,
    input  logic                in_MemWr,
    input  logic                in_done,
    input  logic                in_error,
    input  logic [XLEN-1:0]     in_result,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [PC_W-1:0]     in_nxtpc,
    input  logic [2:0]          in_MemOp,
    input  logic [RD_W-1:0]     in_rd,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wr,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_data,
    input  logic                mem_rsp_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_RegWr,
    output logic                out_done,
    output logic                out_error,
    output logic [RD_W-1:0]     out_rd,
    output logic [XLEN-1:0]     out_wbdata,
    output logic [PC_W-1:0]     out_nxtpc,
    output logic                ld_pending,
    output logic [RD_W-1:0]     ld_rd
);

    localparam int MASK_W = XLEN / 8;
    localparam int OFF_W  = $clog2(MASK_W);

    mem_state_e        state_q, state_d;
    logic              rst_done_q;
    logic              regwr_q, regwr_d;
    logic              memrd_q, memrd_d;
    logic              memwr_q, memwr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [2:0]        memop_q, memop_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [PC_W-1:0]   nxtpc_q, nxtpc_d;
    logic [XLEN-1:0]   wbdata_q, wbdata_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [OFF_W-1:0]  off_q, off_d;

    logic              accept;
    logic              is_mem;
    logic              illegal;
    logic              misalign_bad;
    logic              reject;
    logic              go_mem;
    logic [OFF_W-1:0]  in_off;
    logic [7:0]        lane_bits;
    logic [MASK_W-1:0] store_mask;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   load_data;
    logic              req_active;

    assign in_ready = rst_done_q &
                      ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    assign in_off  = in_result[OFF_W-1:0];
    assign is_mem  = in_MemRd | in_MemWr;
    // Doubleword accesses do not exist on a 32-bit datapath.
    assign illegal = (in_MemRd & in_MemWr) |
                     ((XLEN == 32) & ((in_MemOp == MOP_D) | (in_MemOp == MOP_WU)));

`ifdef YSYX_220066_MISALIGN_CHECK_EN
    assign misalign_bad = (in_result[3:0] & (size_of(in_MemOp) - 4'd1)) != 4'd0;
`else
    assign misalign_bad = 1'b0;
`endif

    assign reject = is_mem & (illegal | misalign_bad);
    assign go_mem = is_mem & ~in_error & ~reject;

    always_comb begin
        lane_bits = 8'hFF;
        case (in_MemOp[1:0])
            2'b00:   lane_bits = 8'h01;
            2'b01:   lane_bits = 8'h03;
            2'b10:   lane_bits = 8'h0F;
            default: lane_bits = 8'hFF;
        endcase
    end

    // Lanes shifted past the top of the word fall off (misaligned, unchecked).
    assign store_mask = MASK_W'(lane_bits) << in_off;
    assign store_data = in_wdata << {in_off, 3'b000};

    ysyx_220066_load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .rsp_data (mem_rsp_data),
        .off      (off_q),
        .mem_op   (memop_q),
        .result   (load_data)
    );

    always_comb begin
        state_d  = state_q;
        regwr_d  = regwr_q;
        memrd_d  = memrd_q;
        memwr_d  = memwr_q;
        done_d   = done_q;
        error_d  = error_q;
        memop_d  = memop_q;
        rd_d     = rd_q;
        nxtpc_d  = nxtpc_q;
        wbdata_d = wbdata_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        off_d    = off_q;

        case (state_q)
            S_REQ: begin
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Only sampled here, so a response in the handshake cycle is ignored.
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    if (memrd_q) wbdata_d = load_data;
                    if (mem_rsp_err) begin
                        error_d = 1'b1;
                        regwr_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            state_d  = go_mem ? S_REQ : S_DONE;
            regwr_d  = in_RegWr & ~reject;
            memrd_d  = in_MemRd;
            memwr_d  = in_MemWr;
            done_d   = in_done;
            error_d  = in_error | reject;
            memop_d  = in_MemOp;
            rd_d     = in_rd;
            nxtpc_d  = in_nxtpc;
            wbdata_d = in_result;
            addr_d   = {in_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            wdata_d  = store_data;
            wmask_d  = store_mask;
            off_d    = in_off;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rst_done_q <= 1'b0;
            regwr_q    <= 1'b0;
            memrd_q    <= 1'b0;
            memwr_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            memop_q    <= '0;
            rd_q       <= '0;
            nxtpc_q    <= '0;
            wbdata_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            regwr_q    <= regwr_d;
            memrd_q    <= memrd_d;
            memwr_q    <= memwr_d;
            done_q     <= done_d;
            error_q    <= error_d;
            memop_q    <= memop_d;
            rd_q       <= rd_d;
            nxtpc_q    <= nxtpc_d;
            wbdata_q   <= wbdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            off_q      <= off_d;
        end
    end

    assign req_active    = (state_q == S_REQ);
    assign mem_req_valid = req_active;
    assign mem_req_wr    = req_active & memwr_q;
    assign mem_addr      = req_active ? addr_q : '0;
    assign mem_wdata     = (req_active & memwr_q) ? wdata_q : '0;
    assign mem_wmask     = (req_active & memwr_q) ? wmask_q : '0;

    assign out_valid  = (state_q == S_DONE);
    assign out_RegWr  = regwr_q;
    assign out_done   = done_q;
    assign out_error  = error_q;
    assign out_rd     = rd_q;
    assign out_wbdata = wbdata_q;
    assign out_nxtpc  = nxtpc_q;

    assign ld_pending = ((state_q == S_REQ) | (state_q == S_WAIT)) & memrd_q;
    assign ld_rd      = ld_pending ? rd_q : '0;

endmodule

// File: tb/tb_ysyx_220066_mem_stage.sv
module tb_ysyx_220066_mem_stage;
    import ysyx_220066_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_RegWr, in_MemRd, in_MemWr, in_done, in_error;
    logic [63:0] in_result, in_wdata, in_nxtpc;
    logic [2:0]  in_MemOp;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_wr;
    logic [63:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid, mem_rsp_err;
    logic        out_valid, out_ready, out_RegWr, out_done, out_error;
    logic [4:0]  out_rd, ld_rd;
    logic [63:0] out_wbdata, out_nxtpc;
    logic        ld_pending;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ysyx_220066_mem_stage #(.XLEN(64), .RD_W(5), .PC_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_RegWr(in_RegWr), .in_MemRd(in_MemRd), .in_MemWr(in_MemWr),
        .in_done(in_done), .in_error(in_error),
        .in_result(in_result), .in_wdata(in_wdata), .in_nxtpc(in_nxtpc),
        .in_MemOp(in_MemOp), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wr(mem_req_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_RegWr(out_RegWr), .out_done(out_done), .out_error(out_error),
        .out_rd(out_rd), .out_wbdata(out_wbdata), .out_nxtpc(out_nxtpc),
        .ld_pending(ld_pending), .ld_rd(ld_rd)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_load(input logic [63:0] d, input logic [63:0] a,
                                             input logic [2:0] op);
        int off, sz;
        logic [63:0] v;
        off = int'(a[2:0]);
        sz  = 1 << op[1:0];
        v   = '0;
        for (int i = 0; i < sz; i++)
            if (off + i < 8) v[8*i +: 8] = d[8*(off+i) +: 8];
        if (op[2] == 1'b0 && sz < 8 && v[8*sz-1] == 1'b1)
            for (int j = 8*sz; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [63:0] a, input logic [2:0] op);
        int off, sz;
        logic [7:0] m;
        off = int'(a[2:0]);
        sz  = 1 << op[1:0];
        m   = '0;
        for (int i = 0; i < sz; i++)
            if (off + i < 8) m[off+i] = 1'b1;
        return m;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_op(input logic rg, input logic mr, input logic mw, input logic dn,
                            input logic er, input logic [2:0] op, input logic [63:0] res,
                            input logic [63:0] wd, input logic [63:0] pc, input logic [4:0] rd);
        in_valid = 1'b1; in_RegWr = rg; in_MemRd = mr; in_MemWr = mw; in_done = dn;
        in_error = er; in_MemOp = op; in_result = res; in_wdata = wd; in_nxtpc = pc;
        in_rd = rd;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Full memory transaction with configurable request stall and response delay.
    task automatic do_mem(input string nm, input logic mr, input logic mw, input logic [2:0] op,
                          input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rsp,
                          input int rdly, input int sdly, input logic err, input logic early);
        logic [4:0]  rd;
        logic [63:0] pc, e_addr, e_wdata, e_load;
        logic [7:0]  e_mask;
        rd      = 5'($urandom);
        pc      = {$urandom, $urandom};
        e_addr  = addr & ~64'h7;
        e_mask  = ref_mask(addr, op);
        e_wdata = wd << (8 * int'(addr[2:0]));
        e_load  = ref_load(rsp, addr, op);

        drive_op(mr, mr, mw, 1'b0, 1'b0, op, addr, wd, pc, rd);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL %s_accept_ready got %b exp 1", nm, in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if ({mem_req_valid, mem_req_wr, mem_addr, in_ready, ld_pending} !== {1'b1, mw, e_addr, 1'b0, mr})
            $display("FAIL %s_req got v=%b wr=%b addr=%h rdy=%b ldp=%b exp v=1 wr=%b addr=%h rdy=0 ldp=%b",
                     nm, mem_req_valid, mem_req_wr, mem_addr, in_ready, ld_pending, mw, e_addr, mr);
        else pass_cnt++;
        if (mw) begin
            total_cnt++;
            if ({mem_wmask, mem_wdata} !== {e_mask, e_wdata})
                $display("FAIL %s_store got mask=%h data=%h exp mask=%h data=%h", nm, mem_wmask, mem_wdata, e_mask, e_wdata);
            else pass_cnt++;
        end
        if (mr) begin
            total_cnt++; if (ld_rd !== rd) $display("FAIL %s_ld_rd got %h exp %h", nm, ld_rd, rd); else pass_cnt++;
        end
        for (int c = 0; c < rdly; c++) begin
            tick();
            total_cnt++;
            if ({mem_req_valid, mem_addr, in_ready} !== {1'b1, e_addr, 1'b0} ||
                (mw && {mem_wmask, mem_wdata} !== {e_mask, e_wdata}))
                $display("FAIL %s_req_stall got v=%b addr=%h rdy=%b mask=%h data=%h exp v=1 addr=%h rdy=0 mask=%h data=%h",
                         nm, mem_req_valid, mem_addr, in_ready, mem_wmask, mem_wdata, e_addr, e_mask, e_wdata);
            else pass_cnt++;
        end
        mem_req_ready = 1'b1;
        if (early) begin mem_rsp_valid = 1'b1; mem_rsp_data = ~rsp; end
        tick();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        total_cnt++;
        if ({mem_req_valid, out_valid} !== 2'b00)
            $display("FAIL %s_wait got req=%b out_valid=%b exp 0 0", nm, mem_req_valid, out_valid);
        else pass_cnt++;
        for (int c = 0; c < sdly; c++) begin
            tick();
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s_wait_dly got %b exp 0", nm, out_valid); else pass_cnt++;
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = rsp; mem_rsp_err = err;
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        total_cnt++;
        if ({out_valid, out_error, out_RegWr, out_rd, out_nxtpc, ld_pending} !== {1'b1, err, mr & ~err, rd, pc, 1'b0})
            $display("FAIL %s_done got v=%b err=%b regwr=%b rd=%h pc=%h ldp=%b exp v=1 err=%b regwr=%b rd=%h pc=%h ldp=0",
                     nm, out_valid, out_error, out_RegWr, out_rd, out_nxtpc, ld_pending, err, mr & ~err, rd, pc);
        else pass_cnt++;
        if (mr && !err) begin
            total_cnt++;
            if (out_wbdata !== e_load) $display("FAIL %s_ldata got %h exp %h", nm, out_wbdata, e_load); else pass_cnt++;
        end
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL %s_idle got %b exp 0", nm, out_valid); else pass_cnt++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        in_valid = 0; in_RegWr = 0; in_MemRd = 0; in_MemWr = 0; in_done = 0; in_error = 0;
        in_result = '0; in_wdata = '0; in_nxtpc = '0; in_MemOp = '0; in_rd = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_err = 0; out_ready = 1;
        #1;
        total_cnt++;
        if ({out_valid, out_RegWr, out_done, out_error, out_rd, out_wbdata, out_nxtpc, mem_req_valid,
             mem_req_wr, mem_addr, mem_wdata, mem_wmask, in_ready, ld_pending, ld_rd} !== '0)
            $display("FAIL reset_outputs got ov=%b rv=%b rdy=%b wb=%h exp all 0", out_valid, mem_req_valid, in_ready, out_wbdata);
        else pass_cnt++;
        tick(); tick();
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_ready_early got %b exp 0", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] vals [3];
        logic [63:0] res, pc;
        logic [4:0]  rd;
        logic        rg, dn, er;
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MOP_D, vals[i], '0, 64'(i), 5'(i + 1));
            tick();
            in_valid = 1'b0;
            total_cnt++;
            if ({out_valid, out_wbdata, mem_req_valid} !== {1'b1, vals[i], 1'b0})
                $display("FAIL b2b_%0d got v=%b wb=%h req=%b exp v=1 wb=%h req=0", i, out_valid, out_wbdata, mem_req_valid, vals[i]);
            else pass_cnt++;
        end
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", out_valid); else pass_cnt++;
        // Random ALU ops with random idle gaps.
        for (int i = 0; i < 12; i++) begin
            res = {$urandom, $urandom}; pc = {$urandom, $urandom}; rd = 5'($urandom);
            rg = 1'($urandom); dn = 1'($urandom); er = ($urandom_range(0, 5) == 0);
            drive_op(rg, 1'b0, 1'b0, dn, er, 3'($urandom_range(0, 6)), res, {$urandom, $urandom}, pc, rd);
            tick();
            in_valid = 1'b0;
            total_cnt++;
            if ({out_valid, out_wbdata, out_nxtpc, out_rd, out_RegWr, out_done, out_error, mem_req_valid} !==
                {1'b1, res, pc, rd, rg, dn, er, 1'b0})
                $display("FAIL alu_rand_%0d got wb=%h pc=%h rd=%h rg=%b dn=%b er=%b exp wb=%h pc=%h rd=%h rg=%b dn=%b er=%b",
                         i, out_wbdata, out_nxtpc, out_rd, out_RegWr, out_done, out_error, res, pc, rd, rg, dn, er);
            else pass_cnt++;
            repeat ($urandom_range(0, 1)) tick();
        end
        tick();
    endtask

    task automatic test_load;
        do_mem("lb",  1'b1, 1'b0, MOP_B,  64'h1003, '0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 1'b0);
        do_mem("lbu", 1'b1, 1'b0, MOP_BU, 64'h1003, '0, 64'h0000_0000_8000_0000, 1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_store_stall;
        do_mem("sh", 1'b0, 1'b1, MOP_H, 64'h1006, 64'hBEEF, '0, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_mem;
        logic        wr;
        logic [2:0]  op;
        logic [63:0] addr;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom);
            op   = wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            addr = {$urandom, $urandom} & ~((64'd1 << op[1:0]) - 64'd1);
            do_mem($sformatf("rmem%0d", i), ~wr, wr, op, addr, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 7) == 0), 1'($urandom));
        end
    endtask

    task automatic test_misaligned;
`ifdef YSYX_220066_MISALIGN_CHECK_EN
        drive_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MOP_W, 64'h1002, '0, 64'h44, 5'd7);
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_error, out_RegWr, mem_req_valid} !== 4'b1100)
            $display("FAIL misalign got v=%b err=%b regwr=%b req=%b exp 1 1 0 0", out_valid, out_error, out_RegWr, mem_req_valid);
        else pass_cnt++;
        tick();
`else
        do_mem("lw_mis", 1'b1, 1'b0, MOP_W, 64'h1002, '0, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0, 1'b0);
        do_mem("sd_mis", 1'b0, 1'b1, MOP_D, 64'h1005, 64'h1122_3344_5566_7788, '0, 1, 0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_illegal;
        drive_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, MOP_D, 64'h2000, '0, 64'h48, 5'd9);
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_error, out_RegWr, mem_req_valid} !== 4'b1100)
            $display("FAIL rdwr_illegal got v=%b err=%b regwr=%b req=%b exp 1 1 0 0", out_valid, out_error, out_RegWr, mem_req_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure;
        logic [63:0] a, b;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MOP_D, a, '0, 64'h10, 5'd3);
        tick();
        out_ready = 1'b0;
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MOP_D, b, '0, 64'h14, 5'd4);
        for (int c = 0; c < 4; c++) begin
            #1;
            total_cnt++;
            if ({out_valid, out_wbdata, out_rd, in_ready} !== {1'b1, a, 5'd3, 1'b0})
                $display("FAIL bp_hold_%0d got v=%b wb=%h rd=%h rdy=%b exp v=1 wb=%h rd=3 rdy=0", c, out_valid, out_wbdata, out_rd, in_ready, a);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b exp 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_wbdata, out_rd} !== {1'b1, b, 5'd4})
            $display("FAIL bp_next got v=%b wb=%h rd=%h exp v=1 wb=%h rd=4", out_valid, out_wbdata, out_rd, b);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_rsp_err;
        do_mem("ld_err", 1'b1, 1'b0, MOP_D, 64'h3008, '0, 64'hDEAD_BEEF_0000_1111, 0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, MOP_D, 64'h4000, '0, 64'h50, 5'd12);
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        total_cnt++; if (ld_pending !== 1'b1) $display("FAIL rstmid_pending got %b exp 1", ld_pending); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, out_RegWr, out_done, out_error, out_rd, out_wbdata, out_nxtpc, mem_req_valid,
             mem_addr, in_ready, ld_pending, ld_rd} !== '0)
            $display("FAIL rstmid_outputs got ov=%b rv=%b rdy=%b ldp=%b wb=%h exp all 0", out_valid, mem_req_valid, in_ready, ld_pending, out_wbdata);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, ld_pending} !== 3'b010)
            $display("FAIL rstmid_idle got v=%b rdy=%b ldp=%b exp 0 1 0", out_valid, in_ready, ld_pending);
        else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_drop got %b exp 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load();
        test_store_stall();
        test_misaligned();
        test_illegal();
        test_backpressure();
        test_rsp_err();
        test_random_mem();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
